// File: rtl/pc_enum_8bit_if.sv
// Stream and control bundle for the same-weight word enumerator.
interface pc_enum_8bit_if;
  logic       start;
  logic [3:0] k;
  logic       abort;
  logic       q_ready;
  logic       q_valid;
  logic [7:0] q;
  logic       q_last;
  logic [6:0] idx;
  logic       busy;
  logic       done;
  logic       err;

  // Requester / consumer side
  modport master (
    output start, k, abort, q_ready,
    input  q_valid, q, q_last, idx, busy, done, err
  );

  // Enumerator side
  modport slave (
    input  start, k, abort, q_ready,
    output q_valid, q, q_last, idx, busy, done, err
  );
endinterface

// File: rtl/pc_enum_8bit.sv
// Enumerates every 8-bit word of popcount k in ascending order, one word per
// accepted valid/ready handshake. Successor words come from Gosper's step.
module pc_enum_8bit (
  input  logic          clk,
  input  logic          rst_n,
  pc_enum_8bit_if.slave bus
);

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e     r_state, w_state_d;
  logic [3:0] r_k, w_k_d;
  logic [7:0] r_q, w_q_d;
  logic [6:0] r_idx, w_idx_d;
  logic       r_err, w_err_d;

  logic [7:0] w_first, w_last, w_next;
  logic [8:0] w_q9, w_c, w_r, w_x;
  logic [2:0] w_ctz;
  logic       w_is_last;
  logic       w_run;

  // First word of a new run and terminal word of the captured weight class
  always_comb begin
    w_first   = 8'((9'd1 << bus.k) - 9'd1);
    w_last    = 8'(16'hFF00 >> r_k);
    w_is_last = (r_q == w_last);
  end

  // Gosper's step at 9 bits so the carry out of bit 7 is not lost
  always_comb begin
    w_q9 = {1'b0, r_q};
    w_c  = w_q9 & (~w_q9 + 9'd1);
    w_r  = w_q9 + w_c;
    w_x  = (w_r ^ w_q9) >> 2;
    // Lowest set bit of c wins; the loop is a priority encoder, not a divider
    w_ctz = 3'd0;
    for (int i = 7; i >= 0; i--) begin
      if (w_c[i]) w_ctz = 3'(i);
    end
    w_next = 8'((w_x >> w_ctz) | w_r);
  end

  // Next-state and datapath update
  always_comb begin
    w_state_d = r_state;
    w_k_d     = r_k;
    w_q_d     = r_q;
    w_idx_d   = r_idx;
    w_err_d   = 1'b0;
    unique case (r_state)
      StIdle: begin
        if (bus.start) begin
          if (bus.k <= 4'd8) begin
            w_state_d = StRun;
            w_k_d     = bus.k;
            w_q_d     = w_first;
            w_idx_d   = 7'd0;
          end else begin
            w_err_d = 1'b1;
          end
        end
      end
      StRun: begin
        // abort wins over any handshake in the same cycle
        if (bus.abort) begin
          w_state_d = StIdle;
        end else if (bus.q_ready) begin
          if (w_is_last) begin
            w_state_d = StDone;
          end else begin
            w_q_d   = w_next;
            w_idx_d = r_idx + 7'd1;
          end
        end
      end
      StDone: begin
        w_state_d = StIdle;
      end
      default: begin
        w_state_d = StIdle;
      end
    endcase
  end

  // State and datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= StIdle;
      r_k     <= 4'd0;
      r_q     <= 8'h00;
      r_idx   <= 7'd0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_state_d;
      r_k     <= w_k_d;
      r_q     <= w_q_d;
      r_idx   <= w_idx_d;
      r_err   <= w_err_d;
    end
  end

  // Outputs decode registers only
  always_comb begin
    w_run       = (r_state == StRun);
    bus.q_valid = w_run;
    bus.busy    = w_run;
    bus.q_last  = w_run && w_is_last;
    bus.done    = (r_state == StDone);
    bus.err     = r_err;
    bus.q       = r_q;
    bus.idx     = r_idx;
  end

endmodule

// File: doc/pc_enum_8bit.md
# pc_enum_8bit

Sequential inverse of the 8-bit population-count lookup. Given a target count k, it enumerates every 8-bit word whose popcount equals k, in ascending numeric order. Words are produced one per accepted handshake on a valid/ready stream, so downstream logic can sweep all patterns of a given weight. It is used for exhaustive weight-class stimulus generation and for weight-constrained code selection next to the popcount path.

## Interface
Parameters:
- none (width fixed at 8 bits; count range 0..8)

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous, active-low reset
- start  input  1  request an enumeration; sampled only in IDLE
- k  input  4  target popcount; sampled with start
- abort  input  1  cancel a running enumeration
- q_ready  input  1  downstream accepts q this cycle
- q_valid  output  1  q holds a valid word
- q  output  8  current word, popcount(q) == k
- q_last  output  1  q is the final word of the sequence
- idx  output  7  zero-based index of q within the sequence (max 69)
- busy  output  1  high in RUN
- done  output  1  one-cycle pulse after the last word is accepted
- err  output  1  one-cycle pulse when start arrives with k > 8

## Operation
- Reset (async, rst_n low): state = IDLE. q_valid, q_last, busy, done and err = 0. q = 8'h00, idx = 0.
- Handshake: a word transfers in any cycle where q_valid && q_ready. While q_valid && !q_ready, q, q_last and idx hold stable.
- State IDLE:
  - start && k <= 8 → RUN. q = (1<<k) - 1 (k=0 gives 8'h00, k=8 gives 8'hFF), idx = 0.
  - start && k > 8 → err pulses for 1 cycle; state stays IDLE.
- State RUN:
  - q_valid = 1 and busy = 1.
  - q_last = (q == (8'hFF << (8-k)) & 8'hFF). For k=0 this is 8'h00, so q_last is set on the first word.
  - On a handshake with !q_last, q advances to the next same-weight word using Gosper's step, evaluated at 9-bit internal width:
    - c = q & -q
    - r = q + c
    - next = (((r ^ q) >> 2) >> ctz(c)) | r, truncated to 8 bits
    - ctz is a priority encoder; no divider.
    - idx increments by 1.
  - On a handshake with q_last → DONE.
  - abort has priority over the handshake: next state IDLE, no done pulse. A word presented in the abort cycle counts as transferred only if q_ready was also high.
- State DONE: done = 1 and q_valid = 0 for one cycle, then IDLE.
- Sequence length is C(8,k): 1, 8, 28, 56, 70, 56, 28, 8, 1 for k = 0..8.
- start is ignored outside IDLE. k is captured at start; later changes on k have no effect.

## Timing
- Start latency: start sampled at edge n gives q_valid = 1 with the first word after edge n.
- Throughput: one word per cycle with q_ready held high. A full sequence occupies C(8,k) RUN cycles, then 1 DONE cycle.
- done is asserted in the cycle after the edge that accepted the q_last word. In that same cycle q_valid = 0.
- Back-to-back runs: a start in the DONE cycle is ignored. The earliest accepted start is in the first IDLE cycle after DONE.
- err is asserted in the cycle after the edge that sampled the illegal start.
- Reset mid-run: all outputs return to their reset values immediately (asynchronous). The next run requires a new start.
- q is registered. q_valid, q_last, busy, done and err are all registered outputs, with no combinational path from any input.

## Test plan
- k=0 with q_ready=1: exactly one word, 8'h00, with q_last=1 and idx=0; done pulses on the next cycle.
- k=2 with q_ready=1: 28 words in the order 8'h03, 05, 06, 09, 0A, 0C, 11, … ending 8'hC0; q_last is high only on 8'hC0; the run takes 28 cycles plus 1 DONE cycle.
- k=4 with random q_ready backpressure: 70 distinct, strictly increasing words, each with popcount 4 checked by the bench's popcount model. q and idx must hold stable during stalls. The final word is 8'hF0 with idx=69.
- k=9, and separately k=15: err pulses for 1 cycle, q_valid stays 0, state stays IDLE; a following start with k=8 yields a single word 8'hFF.
- k=3 with abort at idx=10: the next cycle is IDLE with q_valid=0 and no done; a new start with k=3 restarts at 8'h07, idx=0.
- k=5 with rst_n pulsed low at idx=20: outputs go to zero asynchronously; start asserted while IDLE during RUN-equivalent timing is accepted only after rst_n deasserts.
